pow_5_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one multi-cycle pow_5 engine among N_REQ requesters.
- The engine uses the run/ready interface. The arbiter accepts one request at a time, issues the run pulse, waits for completion (with a watchdog) and returns the result to the granted requester.
- Sits between client blocks and a single sequential pow_5 instance, so only one multiplier datapath is needed.

---
 rtl/pow_5_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_pow_5_share_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pow_5_share_arbiter.sv
// Round-robin front end that shares one sequential pow_5 engine among
// N_REQ requesters. One transaction at a time: accept, run, wait for the
// engine (with a watchdog), then return the result to the granted requester.
//
// Handshakes:
//   request : req_ready[g] is a combinational, one-hot accept pulse in IDLE;
//             the requester holds req_valid/req_n until it sees it.
//   engine  : eng_run is a one-cycle pulse with eng_n, only issued after
//             eng_ready was seen high; the result is taken on the first
//             eng_ready=1 in WAIT.
//   response: resp_valid[id] is a one-cycle, one-hot pulse; resp_data and
//             resp_err are qualified by it and hold until the next response.
module pow_5_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 18,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_n,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   resp_err,
  output logic                   eng_run,
  output logic [WIDTH-1:0]       eng_n,
  input  logic                   eng_ready,
  input  logic [WIDTH-1:0]       eng_res,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] id_q, id_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand;
  logic [WIDTH-1:0] gnt_op;

  // Round-robin scan starting at rr_q; first set request wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(rr_q) + i) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Operand slice of the granted requester.
  always_comb begin
    gnt_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PTR_W'(i) == gnt_idx) gnt_op = req_n[i*WIDTH +: WIDTH];
    end
  end

  // Sequencer next-state and strobes.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    op_d       = op_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    resp_valid = '0;
    eng_run    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // reset_n keeps the accept strobe quiet while reset is asserted.
        if (reset_n && eng_ready && gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          op_d               = gnt_op;
          id_d               = gnt_idx;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_run = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A result arriving on the timeout cycle still counts as a result.
        if (eng_ready) begin
          data_d  = eng_res;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid[id_q] = 1'b1;
        rr_d             = (id_q == PTR_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointer and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // op_q only changes on accept, so eng_n shows it in ISSUE and holds after.
  assign eng_n     = op_q;
  assign resp_data = data_q;
  assign resp_err  = err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pow_5_share_arbiter.sv
// Bench for pow_5_share_arbiter: behavioural pow_5 engine, directed
// requests, and a scoreboard fed by the stimulus and drained by a monitor.
module tb_pow_5_share_arbiter;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 18;
  localparam int TIMEOUT = 64;
  localparam int ENG_LAT = 4;
  localparam int ID_W    = 2;
  localparam int EW      = ID_W + 1 + WIDTH;

  logic                   clock;
  logic                   reset_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_n;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]       resp_data;
  logic                   resp_err;
  logic                   eng_run;
  logic [WIDTH-1:0]       eng_n;
  logic                   eng_ready;
  logic [WIDTH-1:0]       eng_res;
  logic                   busy;
  logic [1:0]             dbg_state;

  logic [WIDTH-1:0] req_n_arr [N_REQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  logic [EW-1:0] exp_q[$];

  logic             eng_stuck;
  logic             eng_block;
  logic             eng_rdy_q;
  int               eng_cnt;
  logic [WIDTH-1:0] eng_op_q;
  logic [WIDTH-1:0] eng_res_q;

  pow_5_share_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .eng_run(eng_run), .eng_n(eng_n), .eng_ready(eng_ready), .eng_res(eng_res),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_n[i*WIDTH +: WIDTH] = req_n_arr[i];
  end

  // ---------------- engine model ----------------
  function automatic logic [WIDTH-1:0] pow5(input logic [WIDTH-1:0] n);
    pow5 = n * n * n * n * n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eng_rdy_q <= 1'b1;
      eng_cnt   <= 0;
      eng_op_q  <= '0;
      eng_res_q <= '0;
    end else if (eng_rdy_q) begin
      if (eng_run) begin
        eng_rdy_q <= 1'b0;
        eng_cnt   <= ENG_LAT - 1;
        eng_op_q  <= eng_n;
      end
    end else if (!eng_stuck) begin
      if (eng_cnt <= 1) begin
        eng_rdy_q <= 1'b1;
        eng_res_q <= pow5(eng_op_q);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  assign eng_ready = eng_rdy_q & ~eng_block;
  assign eng_res   = eng_res_q;

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_resp(input logic [ID_W-1:0] id, input logic [WIDTH-1:0] d,
                             input logic e);
    exp_q.push_back({id, e, d});
  endtask

  task automatic set_req(input logic [ID_W-1:0] id, input logic [WIDTH-1:0] n);
    req_n_arr[id] = n;
    req_valid     = req_valid | (N_REQ'(1) << id);
  endtask

  task automatic wait_accept(input logic [ID_W-1:0] id, output int t);
    logic got;
    got = 1'b0;
    t   = -1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clock);
      if (|(req_ready & (N_REQ'(1) << id))) begin
        got = 1'b1;
        t   = cyc;
        chk("accept_onehot", 32'(req_ready), 32'(N_REQ'(1) << id));
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout req=%0d actual=none required=accept", id);
    end else begin
      @(posedge clock);
      #1;
      req_valid = req_valid & ~(N_REQ'(1) << id);
    end
  endtask

  task automatic wait_resp(input int target);
    for (int k = 0; k < 2000 && resp_cnt < target; k++) begin
      @(negedge clock);
      #1;
    end
    if (resp_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=%0d required=%0d", resp_cnt, target);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
    chk({tag, "_resp_data"}, 32'(resp_data), 0);
    chk({tag, "_resp_err"}, 32'(resp_err), 0);
    chk({tag, "_eng_run"}, 32'(eng_run), 0);
    chk({tag, "_eng_n"}, 32'(eng_n), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [EW-1:0] exp_e;
    logic          prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clock);
      if (prev_v) chk("resp_pulse_1cyc", 32'(resp_valid), 0);
      if (resp_valid != '0) begin
        resp_cnt++;
        resp_cyc = cyc;
        chk("resp_onehot", 32'($onehot(resp_valid)), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected actual=%b required=none", resp_valid);
        end else begin
          exp_e = exp_q.pop_front();
          chk("resp_id", 32'(resp_valid), 32'(N_REQ'(1) << exp_e[EW-1 -: ID_W]));
          chk("resp_data", 32'(resp_data), 32'(exp_e[WIDTH-1:0]));
          chk("resp_err", 32'(resp_err), 32'(exp_e[WIDTH]));
        end
      end
      prev_v = (resp_valid != '0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int t;
    int t_unb;
    int tgt;
    tgt       = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    eng_stuck = 1'b0;
    eng_block = 1'b0;
    for (int i = 0; i < N_REQ; i++) req_n_arr[i] = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk_all_zero("rst");
    @(posedge clock); #1; reset_n = 1'b1;

    // Single request: req0 n=3 -> 243, fixed latency
    set_req(0, 18'd3);
    expect_resp(0, 18'd243, 1'b0);
    wait_accept(0, t);
    @(negedge clock);
    chk("run_pulse", 32'(eng_run), 1);
    chk("run_operand", 32'(eng_n), 3);
    chk("busy_issue", 32'(busy), 1);
    @(negedge clock);
    chk("run_one_cycle", 32'(eng_run), 0);
    chk("eng_n_hold", 32'(eng_n), 3);
    tgt += 1;
    wait_resp(tgt);
    chk("resp_latency", 32'(resp_cyc - t), 6);
    repeat (3) @(negedge clock);
    chk("resp_data_hold", 32'(resp_data), 243);
    chk("idle_not_busy", 32'(busy), 0);

    // Fresh reset, then all four requests at once
    @(posedge clock); #1; reset_n = 1'b0;
    @(posedge clock); #1; reset_n = 1'b1;
    set_req(0, 18'd1);
    set_req(1, 18'd2);
    set_req(2, 18'd7);
    set_req(3, 18'd13);
    expect_resp(0, 18'd1, 1'b0);
    expect_resp(1, 18'd32, 1'b0);
    expect_resp(2, 18'd16807, 1'b0);
    expect_resp(3, 18'd109149, 1'b0);
    wait_accept(0, t);
    wait_accept(1, t);
    wait_accept(2, t);
    wait_accept(3, t);
    tgt += 4;
    wait_resp(tgt);

    // Fairness: req0 and req2 held; pointer wrapped back to 0
    set_req(0, 18'd2);
    set_req(2, 18'd3);
    expect_resp(0, 18'd32, 1'b0);
    expect_resp(2, 18'd243, 1'b0);
    expect_resp(0, 18'd32, 1'b0);
    expect_resp(2, 18'd243, 1'b0);
    tgt += 4;
    wait_resp(tgt);
    req_valid = '0;

    // Engine busy in IDLE: no accept until eng_ready rises
    eng_block = 1'b1;
    set_req(1, 18'd4);
    expect_resp(1, 18'd1024, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("ready_while_eng_busy", 32'(req_ready), 0);
    end
    @(posedge clock); #1;
    eng_block = 1'b0;
    t_unb     = cyc;
    wait_accept(1, t);
    chk("grant_when_eng_ready", 32'(t - t_unb), 0);
    tgt += 1;
    wait_resp(tgt);

    // Engine stuck: timeout response, then normal service
    eng_stuck = 1'b1;
    set_req(2, 18'd6);
    expect_resp(2, 18'd0, 1'b1);
    wait_accept(2, t);
    tgt += 1;
    wait_resp(tgt);
    chk("timeout_latency", 32'(resp_cyc - t), 32'(TIMEOUT + 2));
    eng_stuck = 1'b0;
    set_req(0, 18'd5);
    expect_resp(0, 18'd3125, 1'b0);
    wait_accept(0, t);
    tgt += 1;
    wait_resp(tgt);

    // Reset during WAIT aborts the transaction
    set_req(3, 18'd9);
    wait_accept(3, t);
    repeat (3) @(negedge clock);
    chk("busy_before_abort", 32'(busy), 1);
    #1; reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clock);
    @(posedge clock); #1; reset_n = 1'b1;
    // Pointer must be back at 0: req0 wins over req2
    set_req(0, 18'd7);
    set_req(2, 18'h3FFFF);
    expect_resp(0, 18'd16807, 1'b0);
    expect_resp(2, 18'h3FFFF, 1'b0);
    wait_accept(0, t);
    wait_accept(2, t);
    tgt += 2;
    wait_resp(tgt);
    repeat (20) @(negedge clock);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("resp_total", 32'(resp_cnt), 32'(tgt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
